// File: rtl/pixel_readout_controller.sv
// Frame readout sequencer: selects each pixel row, lets it settle, loads it into the bus
// buffer and then paces one shift/write strobe per output chunk against a valid/ready consumer.
module pixel_readout_controller #(
  parameter int unsigned HEIGHT                 = 2,
  parameter int unsigned WIDTH                  = 2,
  parameter int unsigned OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int unsigned SETTLE_CYCLES          = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              OUT_READY,
  output logic [HEIGHT-1:0] ROW_SELECT,
  output logic              READ_EN,
  output logic              WRITE_EN,
  output logic              OUT_VALID,
  output logic              ROW_LAST,
  output logic              FRAME_LAST,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned NumChunks = WIDTH / OUTPUT_BUS_PIXEL_WIDTH;
  // A zero settle time still spends one cycle in select.
  localparam int unsigned SettleLen = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;
  localparam int unsigned RowW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned SettleW   = (SettleLen > 1) ? $clog2(SettleLen) : 1;

  localparam logic [RowW-1:0]    LastRow    = RowW'(HEIGHT - 1);
  localparam logic [ChunkW-1:0]  LastChunk  = ChunkW'(NumChunks - 1);
  localparam logic [SettleW-1:0] LastSettle = SettleW'(SettleLen - 1);

  typedef enum logic [1:0] {StIdle, StSelect, StLoad, StShift} state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [ChunkW-1:0]   chunk_q, chunk_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                out_valid_q, out_valid_d;
  logic                row_last_q, row_last_d;
  logic                frame_last_q, frame_last_d;
  logic                done_q;
  logic                slot_free;
  logic                accept;

  assign slot_free = !out_valid_q || OUT_READY;
  assign accept    = out_valid_q && OUT_READY;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    chunk_d    = chunk_q;
    settle_d   = settle_q;
    ROW_SELECT = '0;
    READ_EN    = 1'b0;
    WRITE_EN   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A chunk still waiting for the consumer keeps the block busy and blocks a new frame.
        if (START && !out_valid_q) begin
          state_d  = StSelect;
          row_d    = '0;
          settle_d = '0;
        end
      end
      StSelect: begin
        ROW_SELECT = HEIGHT'(1) << row_q;
        if (settle_q == LastSettle) begin
          state_d = StLoad;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLoad: begin
        ROW_SELECT = HEIGHT'(1) << row_q;
        READ_EN    = 1'b1;
        chunk_d    = '0;
        state_d    = StShift;
      end
      StShift: begin
        if (slot_free) begin
          WRITE_EN = 1'b1;
          if (chunk_q == LastChunk) begin
            settle_d = '0;
            if (row_q == LastRow) begin
              state_d = StIdle;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = StSelect;
            end
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    row_last_d   = row_last_q;
    frame_last_d = frame_last_q;
    if (WRITE_EN) begin
      out_valid_d  = 1'b1;
      row_last_d   = (chunk_q == LastChunk);
      frame_last_d = (chunk_q == LastChunk) && (row_q == LastRow);
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      row_q        <= '0;
      chunk_q      <= '0;
      settle_q     <= '0;
      out_valid_q  <= 1'b0;
      row_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      chunk_q      <= chunk_d;
      settle_q     <= settle_d;
      out_valid_q  <= out_valid_d;
      row_last_q   <= row_last_d;
      frame_last_q <= frame_last_d;
      done_q       <= accept && frame_last_q;
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign ROW_LAST   = row_last_q;
  assign FRAME_LAST = frame_last_q;
  assign DONE       = done_q;
  assign BUSY       = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_pixel_readout_controller.sv
// Directed bench: cycle-by-cycle output vectors against hand-built tables for a 2x2-chunk
// configuration and a single-chunk, zero-settle configuration.
module tb_pixel_readout_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start_a, ready_a, start_b, ready_b;
  logic [1:0] row_sel_a;
  logic       read_en_a, write_en_a, out_valid_a, row_last_a, frame_last_a, busy_a, done_a;
  logic [0:0] row_sel_b;
  logic       read_en_b, write_en_b, out_valid_b, row_last_b, frame_last_b, busy_b, done_b;

  int checks = 0;
  int failures = 0;

  // {row_select, read_en, write_en, out_valid, row_last, frame_last, busy, done}
  logic [8:0] exp_a [16];
  logic [7:0] exp_b [10];

  pixel_readout_controller #(
    .HEIGHT(2), .WIDTH(4), .OUTPUT_BUS_PIXEL_WIDTH(2), .SETTLE_CYCLES(2)
  ) dut_a (
    .CLK(clk), .RESET(reset), .START(start_a), .OUT_READY(ready_a),
    .ROW_SELECT(row_sel_a), .READ_EN(read_en_a), .WRITE_EN(write_en_a),
    .OUT_VALID(out_valid_a), .ROW_LAST(row_last_a), .FRAME_LAST(frame_last_a),
    .BUSY(busy_a), .DONE(done_a)
  );

  pixel_readout_controller #(
    .HEIGHT(1), .WIDTH(2), .OUTPUT_BUS_PIXEL_WIDTH(2), .SETTLE_CYCLES(0)
  ) dut_b (
    .CLK(clk), .RESET(reset), .START(start_b), .OUT_READY(ready_b),
    .ROW_SELECT(row_sel_b), .READ_EN(read_en_b), .WRITE_EN(write_en_b),
    .OUT_VALID(out_valid_b), .ROW_LAST(row_last_b), .FRAME_LAST(frame_last_b),
    .BUSY(busy_b), .DONE(done_b)
  );

  function automatic logic [8:0] vec_a();
    return {row_sel_a, read_en_a, write_en_a, out_valid_a, row_last_a, frame_last_a,
            busy_a, done_a};
  endfunction

  function automatic logic [7:0] vec_b();
    return {row_sel_b, read_en_b, write_en_b, out_valid_b, row_last_b, frame_last_b,
            busy_b, done_b};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  // START sampled at edge 0; OUT_READY low during cycles lo..hi.
  task automatic run_a(input string name, input int lo, input int hi, input int exp_acc);
    int acc = 0;
    apply_reset();
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ready_a = !((i + 1) >= lo && (i + 1) <= hi);
      @(negedge clk);
      check_eq($sformatf("%s_cyc%0d", name, i + 1), 32'(vec_a()), 32'(exp_a[i]));
      if (out_valid_a && ready_a) acc++;
      next_cycle();
    end
    check_eq({name, "_accepts"}, acc, exp_acc);
    ready_a = 1'b1;
  endtask

  // START sampled at edge 0 and also held high during cycles lo..hi.
  task automatic run_b(input string name, input int lo, input int hi, input int exp_acc);
    int acc = 0;
    apply_reset();
    start_b = 1'b1;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      start_b = ((i + 1) >= lo && (i + 1) <= hi);
      @(negedge clk);
      check_eq($sformatf("%s_cyc%0d", name, i + 1), 32'(vec_b()), 32'(exp_b[i]));
      if (out_valid_b && ready_b) acc++;
      next_cycle();
    end
    check_eq({name, "_accepts"}, acc, exp_acc);
    start_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    @(negedge clk);
    check_eq("reset_a", 32'(vec_a()), 32'h0);
    check_eq("reset_b", 32'(vec_b()), 32'h0);

    // Reset asserted mid-SHIFT with a pending chunk; START during reset must be ignored.
    apply_reset();
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    repeat (4) next_cycle();
    ready_a = 1'b0;
    @(negedge clk);
    check_eq("rst_pre_c5", 32'(vec_a()), 32'(9'b00_0_0_1_0_0_1_0));
    reset   = 1'b1;
    start_a = 1'b1;
    next_cycle();
    @(negedge clk);
    check_eq("rst_c6", 32'(vec_a()), 32'h0);
    next_cycle();
    reset   = 1'b0;
    start_a = 1'b0;
    ready_a = 1'b1;
    @(negedge clk);
    check_eq("rst_c7", 32'(vec_a()), 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq("rst_c8", 32'(vec_a()), 32'h0);

    exp_a = '{9'b01_0_0_0_0_0_1_0, 9'b01_0_0_0_0_0_1_0, 9'b01_1_0_0_0_0_1_0,
              9'b00_0_1_0_0_0_1_0, 9'b00_0_1_1_0_0_1_0, 9'b10_0_0_1_1_0_1_0,
              9'b10_0_0_0_1_0_1_0, 9'b10_1_0_0_1_0_1_0, 9'b00_0_1_0_1_0_1_0,
              9'b00_0_1_1_0_0_1_0, 9'b00_0_0_1_1_1_1_0, 9'b00_0_0_0_1_1_0_1,
              9'b00_0_0_0_1_1_0_0, 9'b00_0_0_0_1_1_0_0, 9'b00_0_0_0_1_1_0_0,
              9'b00_0_0_0_1_1_0_0};
    run_a("nominal", 100, 0, 4);

    exp_a = '{9'b01_0_0_0_0_0_1_0, 9'b01_0_0_0_0_0_1_0, 9'b01_1_0_0_0_0_1_0,
              9'b00_0_1_0_0_0_1_0, 9'b00_0_0_1_0_0_1_0, 9'b00_0_0_1_0_0_1_0,
              9'b00_0_0_1_0_0_1_0, 9'b00_0_0_1_0_0_1_0, 9'b00_0_1_1_0_0_1_0,
              9'b10_0_0_1_1_0_1_0, 9'b10_0_0_0_1_0_1_0, 9'b10_1_0_0_1_0_1_0,
              9'b00_0_1_0_1_0_1_0, 9'b00_0_1_1_0_0_1_0, 9'b00_0_0_1_1_1_1_0,
              9'b00_0_0_0_1_1_0_1};
    run_a("backpressure", 5, 8, 4);

    exp_a = '{9'b01_0_0_0_0_0_1_0, 9'b01_0_0_0_0_0_1_0, 9'b01_1_0_0_0_0_1_0,
              9'b00_0_1_0_0_0_1_0, 9'b00_0_1_1_0_0_1_0, 9'b10_0_0_1_1_0_1_0,
              9'b10_0_0_1_1_0_1_0, 9'b10_1_0_1_1_0_1_0, 9'b00_0_0_1_1_0_1_0,
              9'b00_0_0_1_1_0_1_0, 9'b00_0_1_1_1_0_1_0, 9'b00_0_1_1_0_0_1_0,
              9'b00_0_0_1_1_1_1_0, 9'b00_0_0_0_1_1_0_1, 9'b00_0_0_0_1_1_0_0,
              9'b00_0_0_0_1_1_0_0};
    run_a("overlap", 6, 10, 4);

    exp_b = '{8'b1_0_0_0_0_0_1_0, 8'b1_1_0_0_0_0_1_0, 8'b0_0_1_0_0_0_1_0,
              8'b0_0_0_1_1_1_1_0, 8'b0_0_0_0_1_1_0_1, 8'b0_0_0_0_1_1_0_0,
              8'b0_0_0_0_1_1_0_0, 8'b0_0_0_0_1_1_0_0, 8'b0_0_0_0_1_1_0_0,
              8'b0_0_0_0_1_1_0_0};
    run_b("single", 2, 3, 1);

    exp_b = '{8'b1_0_0_0_0_0_1_0, 8'b1_1_0_0_0_0_1_0, 8'b0_0_1_0_0_0_1_0,
              8'b0_0_0_1_1_1_1_0, 8'b0_0_0_0_1_1_0_1, 8'b1_0_0_0_1_1_1_0,
              8'b1_1_0_0_1_1_1_0, 8'b0_0_1_0_1_1_1_0, 8'b0_0_0_1_1_1_1_0,
              8'b0_0_0_0_1_1_0_1};
    run_b("b2b", 1, 9, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
